uart_rx_oversampled: RTL and testbench

//  Asynchronous serial (8N1-style) receiver; counterpart of the team's UART transmitter path.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_baud_tick.sv | 37 +++
 rtl/uart_rx_oversampled.sv | 207 ++++++++++++++++++++
 tb/tb_uart_rx_oversampled.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART types, line constants and baud divider helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    localparam logic c_LINE_IDLE = 1'b1;

    // Rounded clock cycles per oversample tick.
    function automatic int calc_div(input int clk_hz, input int baud, input int os);
        int unsigned w_den;
        w_den = baud * os;
        return int'((clk_hz + (w_den / 2)) / w_den);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
//  Module      : uart_baud_tick
//  Description : Free-running divider producing a one-cycle OVERSAMPLE x baud tick.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_tick #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic clock_in,
    input  logic rst,
    output logic o_tick
);
    import uart_pkg::*;

    localparam int DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] c_LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clock_in or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_cnt == c_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_rx_oversampled.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_oversampled
//  Description : Oversampled asynchronous serial receiver with valid/ready output.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_oversampled #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clock_in,
    input  logic                 rst,
    input  logic                 rx_in,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun_err,
    output logic                 busy
);
    import uart_pkg::*;

    localparam int OSW = $clog2(OVERSAMPLE);
    localparam int BCW = $clog2(DATA_BITS + 1);
    localparam logic [OSW-1:0] c_OS_HALF  = OSW'(OVERSAMPLE / 2 - 1);
    localparam logic [OSW-1:0] c_OS_LAST  = OSW'(OVERSAMPLE - 1);
    localparam logic [BCW-1:0] c_BIT_LAST = BCW'(DATA_BITS - 1);

    logic                 w_tick;
    logic                 r_sync_meta;
    logic                 r_sync;
    logic                 w_rx_s;
    logic                 r_prev_s;

    rx_state_t            r_state,    w_state_nxt;
    logic [OSW-1:0]       r_os_cnt,   w_os_nxt;
    logic [BCW-1:0]       r_bit_cnt,  w_bit_nxt;
    logic [DATA_BITS-1:0] r_shift,    w_shift_nxt;
    logic [DATA_BITS:0]   w_shift_cat;
    logic                 r_par_bit,  w_par_nxt;
    logic                 r_stop_bit, w_stop_nxt;
    logic                 r_done,     w_done_nxt;
    logic                 w_par_err;

    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_frame_err;
    logic                 r_parity_err;
    logic                 r_overrun;

    uart_baud_tick #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_tick (
        .clock_in (clock_in),
        .rst      (rst),
        .o_tick   (w_tick)
    );

    always_ff @(posedge clock_in or posedge rst) begin
        if (rst) begin
            r_sync_meta <= c_LINE_IDLE;
            r_sync      <= c_LINE_IDLE;
            r_prev_s    <= c_LINE_IDLE;
        end else begin
            r_sync_meta <= rx_in;
            r_sync      <= r_sync_meta;
            if (w_tick) begin
                r_prev_s <= w_rx_s;
            end
        end
    end

    assign w_rx_s      = r_sync;
    assign w_shift_cat = {w_rx_s, r_shift};

    // A start needs a falling edge between ticks, so a held-low line cannot retrigger.
    always_comb begin
        w_state_nxt = r_state;
        w_os_nxt    = r_os_cnt;
        w_bit_nxt   = r_bit_cnt;
        w_shift_nxt = r_shift;
        w_par_nxt   = r_par_bit;
        w_stop_nxt  = r_stop_bit;
        w_done_nxt  = 1'b0;
        if (w_tick) begin
            case (r_state)
                IDLE: begin
                    if (!w_rx_s && r_prev_s) begin
                        w_state_nxt = START;
                        w_os_nxt    = '0;
                    end
                end
                START: begin
                    if (r_os_cnt == c_OS_HALF) begin
                        w_os_nxt = '0;
                        if (w_rx_s) begin
                            w_state_nxt = IDLE;
                        end else begin
                            w_state_nxt = DATA;
                            w_bit_nxt   = '0;
                        end
                    end else begin
                        w_os_nxt = r_os_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (r_os_cnt == c_OS_LAST) begin
                        w_os_nxt    = '0;
                        w_shift_nxt = w_shift_cat[DATA_BITS:1];
                        w_bit_nxt   = r_bit_cnt + 1'b1;
                        if (r_bit_cnt == c_BIT_LAST) begin
                            w_state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
                        end
                    end else begin
                        w_os_nxt = r_os_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (r_os_cnt == c_OS_LAST) begin
                        w_os_nxt    = '0;
                        w_par_nxt   = w_rx_s;
                        w_state_nxt = STOP;
                    end else begin
                        w_os_nxt = r_os_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (r_os_cnt == c_OS_LAST) begin
                        w_os_nxt    = '0;
                        w_stop_nxt  = w_rx_s;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_os_nxt = r_os_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_os_nxt    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock_in or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_os_cnt   <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_par_bit  <= 1'b0;
            r_stop_bit <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_os_cnt   <= w_os_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
            r_par_bit  <= w_par_nxt;
            r_stop_bit <= w_stop_nxt;
            r_done     <= w_done_nxt;
        end
    end

    assign w_par_err = (PARITY_EN != 0) ? ((^r_shift) ^ r_par_bit ^ (PARITY_ODD != 0)) : 1'b0;

    // Acceptance in the completion cycle frees the slot, so the new word loads without overrun.
    always_ff @(posedge clock_in or posedge rst) begin
        if (rst) begin
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (r_done) begin
                if (!r_valid || rx_ready) begin
                    r_data       <= r_shift;
                    r_frame_err  <= ~r_stop_bit;
                    r_parity_err <= w_par_err;
                    r_valid      <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && rx_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rx_data     = r_data;
    assign rx_valid    = r_valid;
    assign frame_err   = r_frame_err;
    assign parity_err  = r_parity_err;
    assign overrun_err = r_overrun;
    assign busy        = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_oversampled.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_oversampled
//  Description : Self-checking bench: frame generator, accepted-word monitor, reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_oversampled;

    // 6.4 MHz / (100 kBd * 16) gives a divider of 4, so one bit is 64 clocks.
    localparam int CLK_HZ   = 6_400_000;
    localparam int BAUD     = 100_000;
    localparam int OS       = 16;
    localparam int BIT_CLKS = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic       line_a, line_p, rdy_a, rdy_p;
    logic [7:0] a_data, p_data;
    logic       a_valid, a_fe, a_pe, a_ovr, a_busy;
    logic       p_valid, p_fe, p_pe, p_ovr, p_busy;

    int         n_vec = 0;
    int         n_err = 0;
    logic [9:0] q_a[$];
    logic [9:0] q_p[$];
    int         ov_a = 0;
    int         vcyc_a = 0;
    bit         busy_seen_a = 1'b0;

    always #5 clk = ~clk;

    uart_rx_oversampled #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS), .DATA_BITS(8),
        .PARITY_EN(0), .PARITY_ODD(0)
    ) dut_a (
        .clock_in(clk), .rst(rst), .rx_in(line_a), .rx_ready(rdy_a),
        .rx_data(a_data), .rx_valid(a_valid), .frame_err(a_fe), .parity_err(a_pe),
        .overrun_err(a_ovr), .busy(a_busy)
    );

    uart_rx_oversampled #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS), .DATA_BITS(8),
        .PARITY_EN(1), .PARITY_ODD(0)
    ) dut_p (
        .clock_in(clk), .rst(rst), .rx_in(line_p), .rx_ready(rdy_p),
        .rx_data(p_data), .rx_valid(p_valid), .frame_err(p_fe), .parity_err(p_pe),
        .overrun_err(p_ovr), .busy(p_busy)
    );

    // Records every word at the moment it is handed over.
    always @(negedge clk) begin
        if (a_valid && rdy_a) q_a.push_back({a_fe, a_pe, a_data});
        if (p_valid && rdy_p) q_p.push_back({p_fe, p_pe, p_data});
        if (a_ovr) ov_a++;
        if (a_valid) vcyc_a++;
        if (a_busy) busy_seen_a = 1'b1;
    end

    // Expected {frame_err, parity_err, data}; even parity: total ones must be even.
    function automatic logic [9:0] model(input logic [7:0] d, input bit use_par,
                                         input bit par, input bit stop);
        bit pe;
        pe = use_par ? ((($countones(d) + int'(par)) % 2) == 1) : 1'b0;
        return {~stop, pe, d};
    endfunction

    task automatic drive_frame(input bit sel, input logic [7:0] d, input bit use_par,
                               input bit par, input bit stop);
        logic [10:0] bits;
        int          n;
        bits = '0;
        bits[8:1] = d;
        if (use_par) begin
            bits[9] = par; bits[10] = stop; n = 11;
        end else begin
            bits[9] = stop; n = 10;
        end
        for (int i = 0; i < n; i++) begin
            if (sel) line_p = bits[i];
            else     line_a = bits[i];
            repeat (BIT_CLKS) @(posedge clk);
            #1;
        end
    endtask

    task automatic hold_line(input bit sel, input bit lvl, input int nbits);
        if (sel) line_p = lvl;
        else     line_a = lvl;
        repeat (nbits * BIT_CLKS) @(posedge clk);
        #1;
    endtask

    function automatic logic [9:0] q_a_at(input int i);
        return (q_a.size() > i) ? q_a[i] : 10'h3FF;
    endfunction

    function automatic logic [9:0] q_p_at(input int i);
        return (q_p.size() > i) ? q_p[i] : 10'h3FF;
    endfunction

    task automatic test_reset;
        rst = 1'b1; line_a = 1'b1; line_p = 1'b1; rdy_a = 1'b0; rdy_p = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({a_data, a_valid, a_fe, a_pe, a_ovr, a_busy} !== 13'h0) begin
            n_err++; $display("FAIL reset_a: got %h want 0", {a_data, a_valid, a_fe, a_pe, a_ovr, a_busy});
        end
        n_vec++;
        if ({p_data, p_valid, p_fe, p_pe, p_ovr, p_busy} !== 13'h0) begin
            n_err++; $display("FAIL reset_p: got %h want 0", {p_data, p_valid, p_fe, p_pe, p_ovr, p_busy});
        end
        @(posedge clk); #1 rst = 1'b0;
        repeat (BIT_CLKS) @(posedge clk);
        #1;
    endtask

    task automatic test_basic;
        rdy_a = 1'b1; q_a.delete(); vcyc_a = 0;
        drive_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
        hold_line(1'b0, 1'b1, 2);
        n_vec++;
        if (q_a.size() != 1) begin n_err++; $display("FAIL basic_count: got %0d want 1", q_a.size()); end
        n_vec++;
        if (q_a_at(0) !== model(8'hA5, 0, 0, 1)) begin
            n_err++; $display("FAIL basic_word: got %h want %h", q_a_at(0), model(8'hA5, 0, 0, 1));
        end
        n_vec++;
        if (vcyc_a != 1) begin n_err++; $display("FAIL basic_valid_len: got %0d want 1", vcyc_a); end
    endtask

    task automatic test_glitch;
        q_a.delete(); vcyc_a = 0; busy_seen_a = 1'b0;
        line_a = 1'b0;
        repeat (4 * 4) @(posedge clk);
        #1 line_a = 1'b1;
        repeat (8 * 4) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (busy_seen_a !== 1'b1) begin n_err++; $display("FAIL glitch_busy_seen: got %0b want 1", busy_seen_a); end
        n_vec++;
        if (a_busy !== 1'b0) begin n_err++; $display("FAIL glitch_busy_drop: got %0b want 0", a_busy); end
        hold_line(1'b0, 1'b1, 2);
        n_vec++;
        if (vcyc_a != 0) begin n_err++; $display("FAIL glitch_no_valid: got %0d want 0", vcyc_a); end
    endtask

    task automatic test_frame_err;
        q_a.delete();
        drive_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
        hold_line(1'b0, 1'b1, 2);
        drive_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b1);
        hold_line(1'b0, 1'b1, 2);
        n_vec++;
        if (q_a_at(0) !== model(8'h3C, 0, 0, 0)) begin
            n_err++; $display("FAIL ferr_bad: got %h want %h", q_a_at(0), model(8'h3C, 0, 0, 0));
        end
        n_vec++;
        if (q_a_at(1) !== model(8'h55, 0, 0, 1)) begin
            n_err++; $display("FAIL ferr_good: got %h want %h", q_a_at(1), model(8'h55, 0, 0, 1));
        end
    endtask

    task automatic test_break;
        q_a.delete();
        drive_frame(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        hold_line(1'b0, 1'b0, 3);
        hold_line(1'b0, 1'b1, 2);
        n_vec++;
        if (q_a.size() != 1) begin n_err++; $display("FAIL break_count: got %0d want 1", q_a.size()); end
        n_vec++;
        if (q_a_at(0) !== model(8'h00, 0, 0, 0)) begin
            n_err++; $display("FAIL break_word: got %h want %h", q_a_at(0), model(8'h00, 0, 0, 0));
        end
    endtask

    task automatic test_overrun;
        rdy_a = 1'b0; q_a.delete(); ov_a = 0;
        drive_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
        hold_line(1'b0, 1'b1, 1);
        drive_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
        hold_line(1'b0, 1'b1, 2);
        @(negedge clk);
        n_vec++;
        if (ov_a != 1) begin n_err++; $display("FAIL overrun_pulses: got %0d want 1", ov_a); end
        n_vec++;
        if ({a_valid, a_fe, a_pe, a_data} !== {1'b1, 1'b0, 1'b0, 8'h11}) begin
            n_err++; $display("FAIL overrun_hold: got %h want %h", {a_valid, a_fe, a_pe, a_data}, {3'b100, 8'h11});
        end
        @(posedge clk); #1 rdy_a = 1'b1;
        @(posedge clk); #1 rdy_a = 1'b0;
        @(negedge clk);
        n_vec++;
        if (a_valid !== 1'b0) begin n_err++; $display("FAIL overrun_accept: got %0b want 0", a_valid); end
        n_vec++;
        if (q_a_at(0) !== model(8'h11, 0, 0, 1)) begin
            n_err++; $display("FAIL overrun_word: got %h want %h", q_a_at(0), model(8'h11, 0, 0, 1));
        end
    endtask

    task automatic test_back_to_back;
        bit seen;
        bit hit;
        rdy_a = 1'b0; q_a.delete(); ov_a = 0;
        drive_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
        hold_line(1'b0, 1'b1, 1);
        seen = 1'b0; hit = 1'b0;
        fork
            drive_frame(1'b0, 8'hC3, 1'b0, 1'b0, 1'b1);
            begin
                // The FSM leaves STOP one clock before the word lands; accept in that gap.
                for (int c = 0; c < 20 * BIT_CLKS && !hit; c++) begin
                    @(posedge clk); #1;
                    if (seen && !a_busy) begin
                        rdy_a = 1'b1;
                        @(posedge clk); #1 rdy_a = 1'b0;
                        hit = 1'b1;
                    end else if (a_busy) begin
                        seen = 1'b1;
                    end
                end
            end
        join
        hold_line(1'b0, 1'b1, 1);
        @(negedge clk);
        n_vec++;
        if (hit !== 1'b1) begin n_err++; $display("FAIL b2b_timeout: got %0b want 1", hit); end
        n_vec++;
        if (ov_a != 0) begin n_err++; $display("FAIL b2b_overrun: got %0d want 0", ov_a); end
        n_vec++;
        if ({a_valid, a_data} !== {1'b1, 8'hC3}) begin
            n_err++; $display("FAIL b2b_new_word: got %h want %h", {a_valid, a_data}, {1'b1, 8'hC3});
        end
        n_vec++;
        if (q_a_at(0) !== model(8'h5A, 0, 0, 1)) begin
            n_err++; $display("FAIL b2b_old_word: got %h want %h", q_a_at(0), model(8'h5A, 0, 0, 1));
        end
        rdy_a = 1'b1;
        hold_line(1'b0, 1'b1, 1);
    endtask

    task automatic test_parity;
        q_p.delete();
        drive_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
        hold_line(1'b1, 1'b1, 2);
        drive_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
        hold_line(1'b1, 1'b1, 2);
        n_vec++;
        if (q_p_at(0) !== 10'b01_0000_0111) begin
            n_err++; $display("FAIL parity_bad: got %h want %h", q_p_at(0), 10'b01_0000_0111);
        end
        n_vec++;
        if (q_p_at(1) !== 10'b00_0000_0111) begin
            n_err++; $display("FAIL parity_good: got %h want %h", q_p_at(1), 10'b00_0000_0111);
        end
    endtask

    task automatic test_reset_mid;
        rdy_a = 1'b1; q_a.delete();
        fork
            drive_frame(1'b0, 8'hFF, 1'b0, 1'b0, 1'b1);
            begin
                repeat (4 * BIT_CLKS) @(posedge clk);
                @(negedge clk);
                n_vec++;
                if (a_busy !== 1'b1) begin n_err++; $display("FAIL rstmid_busy: got %0b want 1", a_busy); end
                #3 rst = 1'b1;
                #1;
                n_vec++;
                if ({a_data, a_valid, a_fe, a_pe, a_ovr, a_busy} !== 13'h0) begin
                    n_err++; $display("FAIL rstmid_outputs: got %h want 0", {a_data, a_valid, a_fe, a_pe, a_ovr, a_busy});
                end
                @(posedge clk); @(posedge clk); #1 rst = 1'b0;
            end
        join
        hold_line(1'b0, 1'b1, 1);
        drive_frame(1'b0, 8'h81, 1'b0, 1'b0, 1'b1);
        hold_line(1'b0, 1'b1, 2);
        n_vec++;
        if (q_a.size() != 1) begin n_err++; $display("FAIL rstmid_count: got %0d want 1", q_a.size()); end
        n_vec++;
        if (q_a_at(0) !== model(8'h81, 0, 0, 1)) begin
            n_err++; $display("FAIL rstmid_word: got %h want %h", q_a_at(0), model(8'h81, 0, 0, 1));
        end
    endtask

    task automatic test_random;
        logic [9:0] exp_a[$];
        logic [9:0] exp_p[$];
        logic [7:0] d;
        bit         stop, par;
        int         gap;
        rdy_a = 1'b1; q_a.delete(); q_p.delete();
        for (int k = 0; k < 12; k++) begin
            d    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            gap  = stop ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
            drive_frame(1'b0, d, 1'b0, 1'b0, stop);
            exp_a.push_back(model(d, 1'b0, 1'b0, stop));
            hold_line(1'b0, 1'b1, gap);
        end
        hold_line(1'b0, 1'b1, 1);
        for (int k = 0; k < 8; k++) begin
            d   = 8'($urandom);
            par = 1'($urandom);
            drive_frame(1'b1, d, 1'b1, par, 1'b1);
            exp_p.push_back(model(d, 1'b1, par, 1'b1));
            hold_line(1'b1, 1'b1, int'($urandom_range(0, 1)));
        end
        hold_line(1'b1, 1'b1, 1);
        n_vec++;
        if (q_a.size() != exp_a.size()) begin
            n_err++; $display("FAIL rand_count_a: got %0d want %0d", q_a.size(), exp_a.size());
        end
        for (int k = 0; k < exp_a.size(); k++) begin
            n_vec++;
            if (q_a_at(k) !== exp_a[k]) begin
                n_err++; $display("FAIL rand_a[%0d]: got %h want %h", k, q_a_at(k), exp_a[k]);
            end
        end
        n_vec++;
        if (q_p.size() != exp_p.size()) begin
            n_err++; $display("FAIL rand_count_p: got %0d want %0d", q_p.size(), exp_p.size());
        end
        for (int k = 0; k < exp_p.size(); k++) begin
            n_vec++;
            if (q_p_at(k) !== exp_p[k]) begin
                n_err++; $display("FAIL rand_p[%0d]: got %h want %h", k, q_p_at(k), exp_p[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_break();
        test_overrun();
        test_back_to_back();
        test_parity();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
